// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default widths for the data-memory arbiter.
//   state_t : host burst FSM states (IDLE, BURST, DONE)
//   owner_t : last owner of the memory port (round-robin build only)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int AW_DEF         = 8;
    localparam int DW_DEF         = 8;
    localparam int LENW_DEF       = 8;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_burst.sv
// -----------------------------------------------------------------------------
// dmem_arb_burst
// Burst address / beat-count generator for the host port.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_load         latch i_base and i_len (burst start)
//   i_base, i_len  burst start address and beat count
//   i_beat         a host beat used the memory port this cycle
//   o_addr         current burst address
//   o_last         the current beat is the final one of the burst
// -----------------------------------------------------------------------------
module dmem_arb_burst
    import dmem_arb_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_load,
    input  logic [AW-1:0]   i_base,
    input  logic [LENW-1:0] i_len,
    input  logic            i_beat,
    output logic [AW-1:0]   o_addr,
    output logic            o_last
);

    logic [AW-1:0]   r_addr;
    logic [LENW-1:0] r_remaining;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= i_len;
        end else if (i_beat) begin
            // Natural modulo-2^AW wrap: 2^AW-1 rolls over to 0.
            r_addr      <= r_addr + AW'(1);
            r_remaining <= r_remaining - LENW'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remaining == LENW'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port between the core load/store path and a host
// burst port. Core has priority; a starvation counter forces a host beat after
// STARVE_MAX consecutive lost cycles.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration instead
// (owner alternates under contention, no starvation counter).
// Ports:
//   core_*  : core request (held until core_gnt), registered load return
//   host_*  : burst command, write beat handshake, registered read return,
//             busy / done status
//   mem_*   : data_mem interface (combinational read on mem_dout)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int LENW       = LENW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    output logic            core_gnt,
    output logic [DW-1:0]   core_rdata,
    output logic            core_rvalid,
    input  logic            host_start,
    input  logic            host_we,
    input  logic [AW-1:0]   host_base,
    input  logic [LENW-1:0] host_len,
    input  logic [DW-1:0]   host_wdata,
    input  logic            host_wvalid,
    output logic            host_wready,
    output logic [DW-1:0]   host_rdata,
    output logic            host_rvalid,
    output logic            host_busy,
    output logic            host_done,
    output logic            mem_wr_en,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_host_we;
    logic          w_load;
    logic          w_host_pend;
    logic          w_host_win;
    logic          w_last;
    logic [AW-1:0] w_burst_addr;

    // A start is only accepted from IDLE; BURST and DONE both ignore it.
    assign w_load = (r_state == IDLE) & host_start;

    dmem_arb_burst #(
        .AW   (AW),
        .LENW (LENW)
    ) u_burst (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_base  (host_base),
        .i_len   (host_len),
        .i_beat  (w_host_win),
        .o_addr  (w_burst_addr),
        .o_last  (w_last)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_host_we <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_host_we <= host_we;
        end
    end

    // NOTE: next-state is assigned a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (host_start) w_state_nxt = (host_len == '0) ? DONE : BURST;
            BURST:   if (w_host_win && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- arbitration ----------------
    // A read burst always has a beat ready; a write burst only with data.
    assign w_host_pend = (r_state == BURST) & (~r_host_we | host_wvalid);

`ifdef DMEM_ARB_RR_EN
    owner_t r_last_owner;

    // Under contention the side that did not own the port last time wins,
    // which makes ownership alternate every contended cycle.
    assign w_host_win = w_host_pend & (~core_req | (r_last_owner == OWN_CORE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_last_owner <= OWN_CORE;
        else if (w_host_win) r_last_owner <= OWN_HOST;
        else if (core_gnt)   r_last_owner <= OWN_CORE;
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve_cnt;
    logic          w_starved;

    assign w_starved  = (r_starve_cnt == SW'(STARVE_MAX));
    assign w_host_win = w_host_pend & (~core_req | w_starved);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_host_win || !w_host_pend) begin
            r_starve_cnt <= '0;
        end else if (core_gnt && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end
`endif

    assign core_gnt    = core_req & ~w_host_win;
    assign host_wready = w_host_win & r_host_we;
    assign host_busy   = (r_state == BURST);
    assign host_done   = (r_state == DONE);

    // ---------------- memory port mux ----------------
    assign mem_wr_en = w_host_win ? r_host_we    : (core_gnt & core_we);
    assign mem_addr  = w_host_win ? w_burst_addr : core_addr;
    assign mem_din   = w_host_win ? host_wdata   : core_wdata;

    // ---------------- read return ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_rdata  <= '0;
            core_rvalid <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            core_rvalid <= core_gnt & ~core_we;
            host_rvalid <= w_host_win & ~r_host_we;
            if (core_gnt && !core_we)      core_rdata <= mem_dout;
            if (w_host_win && !r_host_we)  host_rdata <= mem_dout;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural data memory
// (combinational read, write on posedge). Inputs change 1 ns after posedge,
// outputs are checked 2 ns after posedge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata;
    logic       core_gnt;
    logic [7:0] core_rdata;
    logic       core_rvalid;
    logic       host_start, host_we;
    logic [7:0] host_base, host_len, host_wdata;
    logic       host_wvalid, host_wready;
    logic [7:0] host_rdata;
    logic       host_rvalid, host_busy, host_done;
    logic       mem_wr_en;
    logic [7:0] mem_addr, mem_din, mem_dout;

    logic [7:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rdata  (core_rdata),
        .core_rvalid (core_rvalid),
        .host_start  (host_start),
        .host_we     (host_we),
        .host_base   (host_base),
        .host_len    (host_len),
        .host_wdata  (host_wdata),
        .host_wvalid (host_wvalid),
        .host_wready (host_wready),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .host_busy   (host_busy),
        .host_done   (host_done),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    // Behavioural data_mem with preloaded contents.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'h3C;
        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;
        mem[8'h22] = 8'h33;
        mem[8'h23] = 8'h44;
        mem[8'h30] = 8'h77;
    end

    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_rd [0:2];
    int         n_beat;
    logic       is_beat, prev_beat;

    initial begin
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33;
        reset_n = 1'b0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_start = 0; host_we = 0; host_base = 0; host_len = 0;
        host_wdata = 0; host_wvalid = 0;

        // ---------------- reset state ----------------
        #2;
        check("rst_gnt",    core_gnt,    0);
        check("rst_busy",   host_busy,   0);
        check("rst_done",   host_done,   0);
        check("rst_wr_en",  mem_wr_en,   0);
        check("rst_rvalid", {core_rvalid, host_rvalid}, 0);
        check("rst_wready", host_wready, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // ---------------- 1: host write burst across the wrap ----------------
        host_start = 1; host_we = 1; host_base = 8'hFE; host_len = 8'd4;
        host_wvalid = 1;
        tick();
        host_start = 0;
        for (int i = 0; i < 4; i++) begin
            host_wdata = 8'hA0 + 8'(i);
            #1;
            check("t1_wr_en",  mem_wr_en,   1);
            check("t1_addr",   mem_addr,    (32'hFE + i) & 32'hFF);
            check("t1_wready", host_wready, 1);
            check("t1_busy",   host_busy,   1);
            check("t1_done",   host_done,   0);
            tick();
        end
        host_wvalid = 0;
        #1;
        check("t1_done_pulse", host_done, 1);
        check("t1_idle_wr",    mem_wr_en, 0);
        check("t1_busy_end",   host_busy, 0);
        tick();
        check("t1_done_clr", host_done, 0);
        check("t1_mem_fe", mem[8'hFE], 8'hA0);
        check("t1_mem_ff", mem[8'hFF], 8'hA1);
        check("t1_mem_00", mem[8'h00], 8'hA2);
        check("t1_mem_01", mem[8'h01], 8'hA3);

        // ---------------- 2: core load and store, no host ----------------
        core_req = 1; core_we = 0; core_addr = 8'h05;
        #1;
        check("t2_gnt",   core_gnt,  1);
        check("t2_addr",  mem_addr,  8'h05);
        check("t2_wr_en", mem_wr_en, 0);
        tick();
        core_we = 1; core_addr = 8'h10; core_wdata = 8'h55;
        #1;
        check("t2_rvalid", core_rvalid, 1);
        check("t2_rdata",  core_rdata,  8'h3C);
        check("t2_st_wr",  mem_wr_en,   1);
        tick();
        core_req = 0; core_we = 0;
        #1;
        check("t2_rvalid_clr", core_rvalid, 0);
        check("t2_mem_10",     mem[8'h10],  8'h55);
        tick();

`ifndef DMEM_ARB_RR_EN
        // ---------------- 3: starvation-forced host reads ----------------
        core_req = 1; core_we = 0; core_addr = 8'h40;
        host_start = 1; host_we = 0; host_base = 8'h20; host_len = 8'd3;
        n_beat = 0; prev_beat = 0;
        for (int c = 0; c <= 16; c++) begin
            #1;
            is_beat = (c == 5) || (c == 10) || (c == 15);
            check("t3_gnt",    core_gnt,    !is_beat);
            check("t3_rvalid", host_rvalid, prev_beat);
            if (prev_beat) check("t3_rdata", host_rdata, exp_rd[n_beat-1]);
            if (is_beat) begin
                check("t3_addr", mem_addr, 32'h20 + n_beat);
                n_beat++;
            end
            if (c == 16) check("t3_done", host_done, 1);
            prev_beat = is_beat;
            tick();
            host_start = 0;
        end
        core_req = 0;
        check("t3_beats", n_beat, 3);
        tick();
`endif

        // ---------------- 4: zero-length burst ----------------
        host_start = 1; host_we = 1; host_base = 8'h60; host_len = 8'd0;
        host_wvalid = 1; host_wdata = 8'hEE;
        #1;
        check("t4_wr_start", mem_wr_en, 0);
        tick();
        host_start = 0;
        #1;
        check("t4_busy", host_busy, 0);
        check("t4_done", host_done, 1);
        check("t4_wr",   mem_wr_en, 0);
        tick();
        check("t4_done_clr", host_done, 0);
        check("t4_busy_clr", host_busy, 0);
        check("t4_mem_60",   mem[8'h60], 8'h00);
        host_wvalid = 0;

        // ---------------- 5: reset mid-burst ----------------
        host_start = 1; host_we = 1; host_base = 8'h80; host_len = 8'd6;
        host_wvalid = 1;
        tick();
        host_start = 0;
        host_wdata = 8'h90; tick();
        host_wdata = 8'h91; tick();
        reset_n = 1'b0;
        #1;
        check("t5_busy",   host_busy,   0);
        check("t5_done",   host_done,   0);
        check("t5_wr_en",  mem_wr_en,   0);
        check("t5_wready", host_wready, 0);
        check("t5_rvalid", {core_rvalid, host_rvalid}, 0);
        check("t5_rdata",  {core_rdata, host_rdata}, 0);
        tick();
        check("t5_done_rst", host_done, 0);
        reset_n = 1'b1;
        host_wvalid = 0;
        tick();
        check("t5_done_after", host_done, 0);
        check("t5_mem_80", mem[8'h80], 8'h90);
        check("t5_mem_81", mem[8'h81], 8'h91);
        check("t5_mem_82", mem[8'h82], 8'h00);
        // New single-beat read burst; a start on its last beat is ignored.
        host_start = 1; host_we = 0; host_base = 8'h30; host_len = 8'd1;
        tick();
        host_base = 8'h50; host_len = 8'd2; // start still high on the last beat
        #1;
        check("t5_new_addr", mem_addr,  8'h30);
        check("t5_new_busy", host_busy, 1);
        tick();
        host_start = 0;
        #1;
        check("t5_new_rvalid", host_rvalid, 1);
        check("t5_new_rdata",  host_rdata,  8'h77);
        check("t5_new_done",   host_done,   1);
        tick();
        check("t5_start_ignored", host_busy, 0);
        tick();
        check("t5_still_idle", host_busy, 0);

`ifdef DMEM_ARB_RR_EN
        // ---------------- 6: round-robin alternation ----------------
        core_req = 1; core_we = 0; core_addr = 8'h05;
        tick();                                   // core is last owner
        core_addr = 8'h40;
        host_start = 1; host_we = 0; host_base = 8'h20; host_len = 8'd4;
        #1;
        check("t6_start_gnt", core_gnt, 1);
        tick();
        host_start = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t6_gnt", core_gnt, (k % 2) == 1);
            tick();
        end
        #1;
        check("t6_last_beat", core_gnt, 0);
        tick();
        core_req = 0;
        #1;
        check("t6_done", host_done, 1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
